// File: rtl/wm8731_i2c_responder.sv
// WM8731-style I2C write target: decodes {dev,W}{reg,d8}{d7:0} frames, ACKs by pulling SDA low,
// and keeps a small 9-bit register file readable by local logic.
module wm8731_i2c_responder #(
    parameter logic [6:0]  DEV_ADDR    = 7'h1A,
    parameter int unsigned NUM_REGS    = 16,
    parameter logic [6:0]  RESET_REG   = 7'h0F,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned AW         = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i2c_sclk,
    input  logic          i2c_sdat_in,
    output logic          i2c_sdat_oe,
    output logic          reg_wr_valid,
    output logic [6:0]    reg_wr_addr,
    output logic [8:0]    reg_wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [8:0]    rd_data,
    output logic          busy
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StAddr    = 3'd1;
    localparam logic [2:0] StAddrAck = 3'd2;
    localparam logic [2:0] StByte1   = 3'd3;
    localparam logic [2:0] StAck1    = 3'd4;
    localparam logic [2:0] StByte2   = 3'd5;
    localparam logic [2:0] StAck2    = 3'd6;
    localparam logic [2:0] StIgnore  = 3'd7;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte1_q, byte1_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       commit;
    logic       valid_q;
    logic [6:0] wr_addr_q;
    logic [8:0] wr_data_q;
    logic [8:0] rd_data_q;
    logic [8:0] regs_q [NUM_REGS];
    logic [6:0] commit_addr;

    // Synchronizers preset to 1 so the bus looks idle coming out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i2c_sclk};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i2c_sdat_in};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s && !scl_prev_q;
    assign scl_fall  = !scl_s && scl_prev_q;
    assign start_det = scl_s && scl_prev_q && sda_prev_q && !sda_s;
    assign stop_det  = scl_s && scl_prev_q && !sda_prev_q && sda_s;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        byte1_d   = byte1_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        commit    = 1'b0;
        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = StIdle;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                StAddr, StByte1, StByte2: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == StAddr) begin
                                if (shift_d[7:1] == DEV_ADDR && !shift_d[0]) begin
                                    state_d = StAddrAck;
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = StIgnore;
                                end
                            end else if (state_q == StByte1) begin
                                byte1_d = shift_d;
                                state_d = StAck1;
                            end else begin
                                state_d = StAck2;
                            end
                        end
                    end
                end
                // First SCL fall starts driving ACK, the second ends the 9th clock.
                StAddrAck, StAck1, StAck2: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d = 1'b0;
                            if (state_q == StAddrAck) begin
                                state_d = StByte1;
                            end else if (state_q == StAck1) begin
                                state_d = StByte2;
                            end else begin
                                state_d = StIgnore;
                                commit  = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign commit_addr = byte1_q[7:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            byte1_q   <= 8'd0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            wr_addr_q <= 7'd0;
            wr_data_q <= 9'd0;
            rd_data_q <= 9'd0;
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= 9'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            byte1_q   <= byte1_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            valid_q   <= commit;
            rd_data_q <= regs_q[rd_addr];
            if (commit) begin
                wr_addr_q <= commit_addr;
                wr_data_q <= {byte1_q[0], shift_q};
                if (commit_addr == RESET_REG) begin
                    for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= 9'd0;
                end else if (32'(commit_addr) < NUM_REGS) begin
                    regs_q[commit_addr[AW-1:0]] <= {byte1_q[0], shift_q};
                end
            end
        end
    end

    assign i2c_sdat_oe  = oe_q;
    assign reg_wr_valid = valid_q;
    assign reg_wr_addr  = wr_addr_q;
    assign reg_wr_data  = wr_data_q;
    assign rd_data      = rd_data_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// Directed bench for wm8731_i2c_responder: a bit-banged I2C master on an open-drain SDA line.
module tb_wm8731_i2c_responder;

    localparam int Q = 10;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [3:0] rd_addr = 4'd0;
    logic       sdat_oe, wr_valid, busy;
    logic [6:0] wr_addr;
    logic [8:0] wr_data, rd_data;
    wire        sda_line = sda_m & ~sdat_oe;

    int         vectors = 0;
    int         miscompares = 0;
    int         valid_cnt = 0;
    logic [6:0] last_addr;
    logic [8:0] last_data, rd_at_valid;

    wm8731_i2c_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i2c_sclk     (scl_m),
        .i2c_sdat_in  (sda_line),
        .i2c_sdat_oe  (sdat_oe),
        .reg_wr_valid (wr_valid),
        .reg_wr_addr  (wr_addr),
        .reg_wr_data  (wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && wr_valid) begin
            valid_cnt   = valid_cnt + 1;
            last_addr   = wr_addr;
            last_data   = wr_data;
            rd_at_valid = rd_data;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; clks(Q);
        scl_m = 1'b1; clks(Q);
        sda_m = 1'b0; clks(Q);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; clks(Q);
        scl_m = 1'b1; clks(Q);
        sda_m = 1'b1; clks(2 * Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; clks(Q);
            scl_m = 1'b1; clks(2 * Q);
            scl_m = 1'b0; clks(Q);
        end
    endtask

    task automatic ack_clock(output logic acked);
        sda_m = 1'b1; clks(Q);
        scl_m = 1'b1; clks(Q);
        acked = (sda_line === 1'b0);
        clks(Q);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        send_bits(b, 8);
        ack_clock(acked);
    endtask

    task automatic write_reg(input logic [6:0] a, input logic [8:0] d);
        logic ack;
        i2c_start();
        send_byte(8'h34, ack);
        send_byte({a, d[8]}, ack);
        send_byte(d[7:0], ack);
        i2c_stop();
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [8:0] d);
        @(negedge clk) rd_addr = a;
        @(negedge clk);
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic test_reset();
        logic [8:0] r;
        @(negedge clk);
        vectors++; if (sdat_oe !== 1'b0) begin miscompares++; $display("FAIL reset_oe got %b want 0", sdat_oe); end
        vectors++; if (wr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", wr_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if ({wr_addr, wr_data} !== 16'h0) begin miscompares++; $display("FAIL reset_wr got %h/%h want 0/0", wr_addr, wr_data); end
        vectors++; if (rd_data !== 9'h0) begin miscompares++; $display("FAIL reset_rd got %h want 000", rd_data); end
        reset_n = 1'b1;
        clks(4);
        read_reg(4'd3, r);
        vectors++; if (r !== 9'h0) begin miscompares++; $display("FAIL reset_reg3 got %h want 000", r); end
    endtask

    task automatic test_basic_write();
        logic a0, a1, a2;
        logic [8:0] r;
        valid_cnt = 0;
        @(negedge clk) rd_addr = 4'd7;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h0E, a1);
        send_byte(8'h42, a2);
        vectors++; if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL basic_acks got %b want 111", {a0, a1, a2}); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %b want 1", busy); end
        i2c_stop();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_stop got %b want 0", busy); end
        vectors++; if (valid_cnt !== 1) begin miscompares++; $display("FAIL basic_valid_cnt got %0d want 1", valid_cnt); end
        vectors++; if ({last_addr, last_data} !== {7'h07, 9'h042}) begin miscompares++; $display("FAIL basic_wr got %h/%h want 07/042", last_addr, last_data); end
        vectors++; if (rd_at_valid !== 9'h000) begin miscompares++; $display("FAIL basic_rd_same_cycle got %h want 000", rd_at_valid); end
        read_reg(4'd7, r);
        vectors++; if (r !== 9'h042) begin miscompares++; $display("FAIL basic_reg7 got %h want 042", r); end
    endtask

    task automatic test_data_msb();
        logic a0, a1, a2;
        logic [8:0] r;
        valid_cnt = 0;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h01, a1);
        send_byte(8'h7F, a2);
        i2c_stop();
        vectors++; if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL msb_acks got %b want 111", {a0, a1, a2}); end
        vectors++; if (valid_cnt !== 1 || {last_addr, last_data} !== {7'h00, 9'h17F}) begin miscompares++; $display("FAIL msb_wr got n=%0d %h/%h want n=1 00/17f", valid_cnt, last_addr, last_data); end
        read_reg(4'd0, r);
        vectors++; if (r !== 9'h17F) begin miscompares++; $display("FAIL msb_reg0 got %h want 17f", r); end
        read_reg(4'd7, r);
        vectors++; if (r !== 9'h042) begin miscompares++; $display("FAIL msb_reg7 got %h want 042", r); end
    endtask

    task automatic test_no_match();
        logic [7:0] addrs [2];
        logic a0, a1, a2;
        addrs[0] = 8'h36;
        addrs[1] = 8'h35;
        for (int k = 0; k < 2; k++) begin
            valid_cnt = 0;
            i2c_start();
            send_byte(addrs[k], a0);
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL nomatch_busy addr=%h got %b want 0", addrs[k], busy); end
            send_byte(8'h0E, a1);
            send_byte(8'h42, a2);
            i2c_stop();
            vectors++; if ({a0, a1, a2} !== 3'b000) begin miscompares++; $display("FAIL nomatch_acks addr=%h got %b want 000", addrs[k], {a0, a1, a2}); end
            vectors++; if (valid_cnt !== 0) begin miscompares++; $display("FAIL nomatch_valid addr=%h got %0d want 0", addrs[k], valid_cnt); end
        end
    endtask

    task automatic test_partial();
        logic a0, a1, a2;
        logic [8:0] r;
        valid_cnt = 0;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h0E, a1);
        i2c_stop();
        vectors++; if ({a0, a1} !== 2'b11) begin miscompares++; $display("FAIL partial_acks got %b want 11", {a0, a1}); end
        vectors++; if (valid_cnt !== 0) begin miscompares++; $display("FAIL partial_valid got %0d want 0", valid_cnt); end
        read_reg(4'd7, r);
        vectors++; if (r !== 9'h042) begin miscompares++; $display("FAIL partial_reg7 got %h want 042", r); end
        // Abandon a frame with a repeated START, then complete a fresh one.
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h0E, a1);
        i2c_start();
        vectors++; if (busy !== 1'b0 || sdat_oe !== 1'b0) begin miscompares++; $display("FAIL rstart_busy got busy=%b oe=%b want 0/0", busy, sdat_oe); end
        send_byte(8'h34, a0);
        send_byte(8'h0E, a1);
        send_byte(8'h99, a2);
        i2c_stop();
        vectors++; if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL rstart_acks got %b want 111", {a0, a1, a2}); end
        vectors++; if (valid_cnt !== 1 || last_data !== 9'h099) begin miscompares++; $display("FAIL rstart_wr got n=%0d %h want n=1 099", valid_cnt, last_data); end
        read_reg(4'd7, r);
        vectors++; if (r !== 9'h099) begin miscompares++; $display("FAIL rstart_reg7 got %h want 099", r); end
    endtask

    task automatic test_reg_reset();
        logic a0, a1, a2;
        logic [8:0] r;
        for (int i = 0; i < 10; i++) write_reg(7'(i), 9'(9'h101 + i * 17));
        read_reg(4'd9, r);
        vectors++; if (r !== 9'h19A) begin miscompares++; $display("FAIL load_reg9 got %h want 19a", r); end
        valid_cnt = 0;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h20, a1);
        send_byte(8'h55, a2);
        i2c_stop();
        vectors++; if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL oor_acks got %b want 111", {a0, a1, a2}); end
        vectors++; if (valid_cnt !== 1 || {last_addr, last_data} !== {7'h10, 9'h055}) begin miscompares++; $display("FAIL oor_wr got n=%0d %h/%h want n=1 10/055", valid_cnt, last_addr, last_data); end
        read_reg(4'd0, r);
        vectors++; if (r !== 9'h101) begin miscompares++; $display("FAIL oor_reg0 got %h want 101", r); end
        valid_cnt = 0;
        write_reg(7'h0F, 9'h000);
        vectors++; if (valid_cnt !== 1 || last_addr !== 7'h0F) begin miscompares++; $display("FAIL rreg_wr got n=%0d %h want n=1 0f", valid_cnt, last_addr); end
        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), r);
            vectors++; if (r !== 9'h000) begin miscompares++; $display("FAIL rreg_clear reg%0d got %h want 000", i, r); end
        end
    endtask

    task automatic test_extra_and_reset();
        logic a0, a1, a2, a3;
        logic [8:0] r;
        valid_cnt = 0;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h0E, a1);
        send_byte(8'h42, a2);
        send_byte(8'h55, a3);
        i2c_stop();
        vectors++; if ({a0, a1, a2, a3} !== 4'b1110) begin miscompares++; $display("FAIL extra_acks got %b want 1110", {a0, a1, a2, a3}); end
        vectors++; if (valid_cnt !== 1 || last_data !== 9'h042) begin miscompares++; $display("FAIL extra_wr got n=%0d %h want n=1 042", valid_cnt, last_data); end
        @(negedge clk) rd_addr = 4'd7;
        valid_cnt = 0;
        i2c_start();
        send_byte(8'h34, a0);
        send_bits(8'h0E, 4);
        @(negedge clk) reset_n = 1'b0;
        clks(3);
        @(negedge clk);
        vectors++; if ({sdat_oe, wr_valid, busy} !== 3'b000) begin miscompares++; $display("FAIL midrst_ctl got oe/v/busy=%b want 000", {sdat_oe, wr_valid, busy}); end
        vectors++; if ({wr_addr, wr_data, rd_data} !== 25'h0) begin miscompares++; $display("FAIL midrst_data got %h/%h/%h want 0/0/0", wr_addr, wr_data, rd_data); end
        reset_n = 1'b1;
        send_bits(8'hE0, 4);
        ack_clock(a1);
        send_byte(8'h42, a2);
        i2c_stop();
        vectors++; if ({a1, a2, valid_cnt[0]} !== 3'b000 || valid_cnt !== 0) begin miscompares++; $display("FAIL midrst_after got acks=%b n=%0d want 00 n=0", {a1, a2}, valid_cnt); end
        write_reg(7'h07, 9'h042);
        read_reg(4'd7, r);
        vectors++; if (valid_cnt !== 1 || r !== 9'h042) begin miscompares++; $display("FAIL midrst_recover got n=%0d %h want n=1 042", valid_cnt, r); end
    endtask

    initial begin
        clks(5);
        test_reset();
        test_basic_write();
        test_data_msb();
        test_no_match();
        test_partial();
        test_reg_reset();
        test_extra_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
